hub75_capture: RTL and testbench

Receive-side model of the LED-matrix panel interface. It samples the shift clock, RGB, latch, output-enable and row-address lines produced by the display driver, rebuilds the 16x32 RGB frame in an internal frame store, and exposes that store through a registered read port with frame and error status. It sits beside the display driver for self-check and bring-up, observing the same pins that go to the panel.

---
 rtl/hub75_capture_if.sv | 12 +
 rtl/hub75_capture.sv | 119 +++++++++++
 tb/tb_hub75_capture.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_capture_if.sv
// hub75_capture_if: HUB75 panel pins shared by the display driver and the capture monitor
interface hub75_capture_if #(
    parameter int ABC_W = 3
);
    logic             panel_clk;
    logic [5:0]       rgb;
    logic             lat;
    logic             oe;
    logic [ABC_W-1:0] abc;
    modport master (output panel_clk, rgb, lat, oe, abc);
    modport slave  (input  panel_clk, rgb, lat, oe, abc);
endinterface

// File: rtl/hub75_capture.sv
// hub75_capture: rebuilds the HUB75 frame from sampled panel pins and exposes it through a registered read port
module hub75_capture #(
    parameter int COLS = 32,
    parameter int ROWS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hub75_capture_if.slave          pins,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic [2:0]              rd_rgb,
    output logic                    blank,
    output logic                    frame_done,
    output logic [7:0]              frame_count,
    output logic                    err_short,
    output logic                    err_overrun,
    input  logic                    err_clr
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(COLS + 1);
    localparam int ABC_W = $clog2(ROWS / 2);
    localparam int SYN_W = 9 + ABC_W;

    logic [SYN_W-1:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                             pclk_prev_q, pclk_prev_d, lat_prev_q, lat_prev_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [COLS-1:0][2:0]             line_top_q, line_top_d, line_bot_q, line_bot_d;
    logic [ROWS-1:0][COLS-1:0][2:0]   frame_q, frame_d;
    logic [2:0]                       rd_rgb_q, rd_rgb_d;
    logic                             commit_q, commit_d, frame_done_q, frame_done_d;
    logic [7:0]                       frame_count_q, frame_count_d;
    logic                             err_short_q, err_short_d, err_overrun_q, err_overrun_d;
    logic                             s_pclk, s_lat, shift, latch;
    logic [5:0]                       s_rgb;
    logic [ABC_W-1:0]                 s_abc;

    // Synchronized pin vector, MSB first: panel_clk, rgb[5:0], lat, oe, abc
    assign s_pclk = sync2_q[SYN_W-1];
    assign s_rgb  = sync2_q[SYN_W-2 -: 6];
    assign s_lat  = sync2_q[ABC_W+1];
    assign s_abc  = sync2_q[ABC_W-1:0];
    assign shift  = s_pclk & ~pclk_prev_q;
    assign latch  = s_lat & ~lat_prev_q;

    always_comb begin
        sync1_d       = {pins.panel_clk, pins.rgb, pins.lat, pins.oe, pins.abc};
        sync2_d       = sync1_q;
        pclk_prev_d   = s_pclk;
        lat_prev_d    = s_lat;
        idx_d         = idx_q;
        line_top_d    = line_top_q;
        line_bot_d    = line_bot_q;
        frame_d       = frame_q;
        err_short_d   = err_clr ? 1'b0 : err_short_q;
        err_overrun_d = err_clr ? 1'b0 : err_overrun_q;
        if (shift) begin
            if (idx_q < IDX_W'(COLS)) begin
                line_top_d[idx_q[COL_W-1:0]] = s_rgb[5:3];
                line_bot_d[idx_q[COL_W-1:0]] = s_rgb[2:0];
                idx_d = idx_q + IDX_W'(1);
            end else begin
                err_overrun_d = 1'b1;
            end
        end
        // The latch commits the line buffer after any same-cycle shift has landed
        if (latch) begin
            frame_d[ROW_W'(s_abc)]                  = line_top_d;
            frame_d[ROW_W'(s_abc) + ROW_W'(ROWS/2)] = line_bot_d;
            err_short_d = (idx_d < IDX_W'(COLS)) ? 1'b1 : err_short_d;
            idx_d = '0;
        end
        commit_d      = latch && (s_abc == ABC_W'(ROWS/2 - 1));
        frame_done_d  = commit_q;
        frame_count_d = frame_count_q + 8'(commit_q);
        rd_rgb_d      = frame_q[rd_row][rd_col];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            pclk_prev_q   <= 1'b0;
            lat_prev_q    <= 1'b0;
            idx_q         <= '0;
            line_top_q    <= '0;
            line_bot_q    <= '0;
            frame_q       <= '0;
            rd_rgb_q      <= '0;
            commit_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pclk_prev_q   <= pclk_prev_d;
            lat_prev_q    <= lat_prev_d;
            idx_q         <= idx_d;
            line_top_q    <= line_top_d;
            line_bot_q    <= line_bot_d;
            frame_q       <= frame_d;
            rd_rgb_q      <= rd_rgb_d;
            commit_q      <= commit_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign rd_rgb      = rd_rgb_q;
    assign blank       = sync2_q[ABC_W];
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: directed vectors and hand-written sequences for the HUB75 capture monitor
module tb_hub75_capture;
    typedef struct {
        int ph;
        int row;
        int col;
        int exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] rd_row;
    logic [4:0] rd_col;
    logic [2:0] rd_rgb;
    logic       blank, frame_done, err_short, err_overrun, err_clr;
    logic [7:0] frame_count;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    vec_t       tv [34];

    hub75_capture_if pins ();

    hub75_capture dut (
        .clk(clk), .reset_n(reset_n), .pins(pins),
        .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
        .blank(blank), .frame_done(frame_done), .frame_count(frame_count),
        .err_short(err_short), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

    function automatic logic [2:0] pat_top(int r, int c);
        return 3'((r + c) & 7);
    endfunction

    function automatic logic [2:0] pat_bot(int r, int c);
        return 3'((r ^ c) & 7);
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic shift(logic [2:0] top, logic [2:0] bot);
        pins.rgb = {top, bot};
        tick(2);
        pins.panel_clk = 1'b1;
        tick(2);
        pins.panel_clk = 1'b0;
    endtask

    task automatic latch(logic [2:0] abc, output logic [5:0] dh, output logic [5:0][2:0] rh);
        pins.abc = abc;
        tick(2);
        pins.lat = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            dh[k] = frame_done;
            rh[k] = rd_rgb;
            if (k == 1) pins.lat = 1'b0;
        end
        tick(2);
    endtask

    task automatic rd(int r, int c, output logic [2:0] v);
        rd_row = 4'(r);
        rd_col = 5'(c);
        tick(1);
        v = rd_rgb;
    endtask

    task automatic run_vecs(int ph);
        logic [2:0] v;
        foreach (tv[i]) begin
            if (tv[i].ph == ph) begin
                rd(tv[i].row, tv[i].col, v);
                chk($sformatf("rd_p%0d_r%0d_c%0d", ph, tv[i].row, tv[i].col), int'(v), tv[i].exp);
            end
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [5:0]      dh;
        logic [5:0][2:0] rh;
        logic [2:0]      v;
        int              bad;
        tv = '{
            '{1, 3, 0, 4}, '{1, 3, 1, 0}, '{1, 3, 30, 4}, '{1, 3, 31, 0},
            '{1, 11, 17, 2}, '{1, 11, 0, 2}, '{1, 2, 0, 0},
            '{2, 2, 0, 7}, '{2, 2, 19, 7}, '{2, 2, 20, 3}, '{2, 2, 31, 6},
            '{2, 10, 5, 1}, '{2, 10, 19, 1}, '{2, 10, 20, 3}, '{2, 10, 31, 0},
            '{3, 4, 0, 0}, '{3, 4, 9, 1}, '{3, 4, 31, 7},
            '{3, 12, 3, 0}, '{3, 12, 8, 2}, '{3, 12, 31, 7},
            '{4, 6, 0, 3}, '{4, 6, 30, 3}, '{4, 6, 31, 6}, '{4, 14, 0, 5}, '{4, 14, 31, 1},
            '{5, 4, 9, 0}, '{5, 6, 31, 0}, '{5, 3, 0, 0}, '{5, 14, 31, 0},
            '{6, 0, 2, 5}, '{6, 0, 7, 0}, '{6, 8, 9, 0}, '{6, 8, 4, 3}
        };
        reset_n = 1'b0;
        pins.panel_clk = 1'b0;
        pins.rgb = '0;
        pins.lat = 1'b0;
        pins.oe = 1'b0;
        pins.abc = '0;
        rd_row = '0;
        rd_col = '0;
        err_clr = 1'b0;
        tick(3);
        chk("rst_rd_rgb", int'(rd_rgb), 0);
        chk("rst_blank", int'(blank), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_err_short", int'(err_short), 0);
        chk("rst_err_overrun", int'(err_overrun), 0);
        reset_n = 1'b1;
        tick(2);
        pins.oe = 1'b1;
        tick(1);
        chk("blank_lag1", int'(blank), 0);
        tick(1);
        chk("blank_lag2", int'(blank), 1);
        pins.oe = 1'b0;

        for (int c = 0; c < 32; c++) shift((c % 2 == 0) ? 3'b100 : 3'b000, 3'b010);
        latch(3'd3, dh, rh);
        run_vecs(1);
        chk("single_err_short", int'(err_short), 0);
        chk("single_err_overrun", int'(err_overrun), 0);
        chk("single_done_cnt", done_cnt, 0);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) shift(pat_top(r, c), pat_bot(r, c));
            latch(3'(r), dh, rh);
            if (r == 7) chk("frame_done_timing", int'(dh), 8);
        end
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 32; c++) begin
                rd(r, c, v);
                if (v !== ((r < 8) ? pat_top(r, c) : pat_bot(r - 8, c))) bad++;
            end
        end
        chk("full_frame_bad_pixels", bad, 0);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_frame_count", int'(frame_count), 1);

        for (int c = 0; c < 20; c++) shift(3'b111, 3'b001);
        latch(3'd2, dh, rh);
        chk("short_err_short", int'(err_short), 1);
        chk("short_err_overrun", int'(err_overrun), 0);
        run_vecs(2);
        clear_errs();
        chk("short_cleared", int'(err_short), 0);

        for (int k = 0; k < 35; k++) shift(3'(k), 3'(k >> 2));
        latch(3'd4, dh, rh);
        chk("over_err_overrun", int'(err_overrun), 1);
        chk("over_err_short", int'(err_short), 0);
        run_vecs(3);
        clear_errs();
        chk("over_cleared", int'(err_overrun), 0);

        for (int c = 0; c < 31; c++) shift(3'b011, 3'b101);
        pins.rgb = {3'b110, 3'b001};
        pins.abc = 3'd6;
        tick(2);
        pins.panel_clk = 1'b1;
        pins.lat = 1'b1;
        tick(2);
        pins.panel_clk = 1'b0;
        pins.lat = 1'b0;
        tick(6);
        chk("simul_err_short", int'(err_short), 0);
        chk("simul_err_overrun", int'(err_overrun), 0);
        run_vecs(4);

        rd_row = 4'd5;
        rd_col = 5'd0;
        for (int c = 0; c < 32; c++) shift(3'b010, 3'b111);
        latch(3'd5, dh, rh);
        chk("collide_old", int'(rh[2]), 5);
        chk("collide_new", int'(rh[3]), 2);
        chk("collide_frame_count", int'(frame_count), 1);

        for (int i = 0; i < 254; i++) latch(3'd7, dh, rh);
        chk("wrap_count_255", int'(frame_count), 255);
        latch(3'd7, dh, rh);
        chk("wrap_count_0", int'(frame_count), 0);
        chk("wrap_done_cnt", done_cnt, 256);

        pins.oe = 1'b1;
        for (int c = 0; c < 10; c++) shift(3'b111, 3'b111);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd_rgb", int'(rd_rgb), 0);
        chk("mid_rst_blank", int'(blank), 0);
        chk("mid_rst_frame_done", int'(frame_done), 0);
        chk("mid_rst_frame_count", int'(frame_count), 0);
        chk("mid_rst_err_short", int'(err_short), 0);
        chk("mid_rst_err_overrun", int'(err_overrun), 0);
        pins.oe = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        run_vecs(5);
        for (int c = 0; c < 5; c++) shift(3'b101, 3'b011);
        latch(3'd0, dh, rh);
        chk("post_rst_err_short", int'(err_short), 1);
        chk("post_rst_frame_count", int'(frame_count), 0);
        run_vecs(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
